// File: rtl/pipe_stage_bank_if.sv
// Entry/exit bus of pipe_stage_bank: one payload group entering stage 0 and
// leaving the oldest stage.
interface pipe_stage_bank_if #(
  parameter int WIDTH = 32
);
  // Valid/ready: an entry moves into stage 0 on a rising clk edge where
  // in_valid && in_ready. An entry leaves the oldest stage on an edge where
  // out_fire is high. out_fire already accounts for a full-bank hold, so a
  // consumer takes out_data whenever out_fire is set and needs no ready of its own.
  logic             in_valid;
  logic [WIDTH-1:0] in_data;
  logic             in_ready;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_fire;

  modport master (
    output in_valid, in_data,
    input  in_ready, out_valid, out_data, out_fire
  );

  modport slave (
    input  in_valid, in_data,
    output in_ready, out_valid, out_data, out_fire
  );
endinterface

// File: rtl/pipe_stage_bank.sv
// DEPTH-stage valid/payload register bank with stall plus bubble insertion,
// youngest-K flush and registered occupancy. Optional PIPE_PERF_EN adds counters.
module pipe_stage_bank #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic                       clk,
  input  logic                       rstn,
  pipe_stage_bank_if.slave           bus,
  input  logic                       stall_req,
  input  logic [$clog2(DEPTH)-1:0]   stall_stage,
  input  logic                       flush_req,
  input  logic [CW-1:0]              flush_cnt,
  output logic [DEPTH-1:0]           stage_valid,
  output logic [DEPTH*WIDTH-1:0]     stage_data,
  output logic [CW-1:0]              occupancy
`ifdef PIPE_PERF_EN
  ,
  output logic [31:0]                bubble_cnt,
  output logic [31:0]                retire_cnt
`endif
);

  logic [DEPTH-1:0] v_q, v_n;
  logic [WIDTH-1:0] d_q [DEPTH];
  logic [WIDTH-1:0] d_n [DEPTH];
  logic [CW-1:0]    occ_q, occ_n;
  logic             hold_mode;
  logic             squash;
  logic             fire;

  // Flush wins over stall; a flush with a zero count is an ordinary shift.
  assign hold_mode = stall_req && !flush_req;
  assign squash    = flush_req && (flush_cnt != '0);

  assign bus.in_ready  = !stall_req || flush_req;
  assign bus.out_valid = v_q[DEPTH-1];
  assign bus.out_data  = d_q[DEPTH-1];
  assign fire          = v_q[DEPTH-1] &&
                         !(hold_mode && (int'(stall_stage) == DEPTH - 1));
  assign bus.out_fire  = fire;

  always_comb begin
    v_n = v_q;
    for (int i = 0; i < DEPTH; i++) d_n[i] = d_q[i];

    // Stage 0 is always inside the held range when stalling.
    if (hold_mode) begin
      v_n[0] = v_q[0];
    end else if (squash) begin
      v_n[0] = 1'b0;
      d_n[0] = '0;
    end else begin
      v_n[0] = bus.in_valid;
      d_n[0] = bus.in_data;
    end

    for (int i = 1; i < DEPTH; i++) begin
      if (hold_mode && i <= int'(stall_stage)) begin
        v_n[i] = v_q[i];
      end else if (hold_mode && i == int'(stall_stage) + 1) begin
        // Bubble keeps its stale payload; only the valid bit drops.
        v_n[i] = 1'b0;
      end else if (squash && (i - 1) < int'(flush_cnt)) begin
        v_n[i] = 1'b0;
        d_n[i] = '0;
      end else begin
        v_n[i] = v_q[i-1];
        d_n[i] = d_q[i-1];
      end
    end

    occ_n = '0;
    for (int i = 0; i < DEPTH; i++) occ_n = occ_n + CW'(v_n[i]);
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      v_q   <= '0;
      occ_q <= '0;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= '0;
    end else begin
      v_q   <= v_n;
      occ_q <= occ_n;
      for (int i = 0; i < DEPTH; i++) d_q[i] <= d_n[i];
    end
  end

  assign stage_valid = v_q;
  assign occupancy   = occ_q;

  for (genvar g = 0; g < DEPTH; g++) begin : g_flat
    assign stage_data[g*WIDTH +: WIDTH] = d_q[g];
  end

`ifdef PIPE_PERF_EN
  // Both counters stick at all-ones instead of wrapping.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      bubble_cnt <= '0;
      retire_cnt <= '0;
    end else begin
      if (!v_q[DEPTH-1] && bubble_cnt != '1) bubble_cnt <= bubble_cnt + 32'd1;
      if (fire && retire_cnt != '1)          retire_cnt <= retire_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_pipe_stage_bank.sv
// Directed bench for pipe_stage_bank (DEPTH=4, WIDTH=32): stream, stall,
// hold, flush, flush+stall, async reset; retired data checked against exp_q.
module tb_pipe_stage_bank;
  localparam int W  = 32;
  localparam int D  = 4;
  localparam int CW = 3;

  logic           clk;
  logic           rstn;
  logic           stall_req;
  logic [1:0]     stall_stage;
  logic           flush_req;
  logic [CW-1:0]  flush_cnt;
  logic [D-1:0]   stage_valid;
  logic [D*W-1:0] stage_data;
  logic [CW-1:0]  occupancy;
`ifdef PIPE_PERF_EN
  logic [31:0]    bubble_cnt;
  logic [31:0]    retire_cnt;
`endif

  pipe_stage_bank_if #(.WIDTH(W)) bus ();

  pipe_stage_bank #(.WIDTH(W), .DEPTH(D)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .bus         (bus),
    .stall_req   (stall_req),
    .stall_stage (stall_stage),
    .flush_req   (flush_req),
    .flush_cnt   (flush_cnt),
    .stage_valid (stage_valid),
    .stage_data  (stage_data),
    .occupancy   (occupancy)
`ifdef PIPE_PERF_EN
    ,
    .bubble_cnt  (bubble_cnt),
    .retire_cnt  (retire_cnt)
`endif
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_err = 0;
  logic [W-1:0] exp_q[$];

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [W-1:0] sd(input int i);
    return stage_data[i*W +: W];
  endfunction

  // One clock: at the falling edge retire/accept against the scoreboard,
  // then return 1ns after the rising edge.
  task automatic tick();
    logic [W-1:0] e;
    @(negedge clk);
    if (bus.out_fire) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_retire", {32'h0, bus.out_data}, 64'hDEAD_DEAD_DEAD_DEAD);
      end else begin
        e = exp_q.pop_front();
        chk("retire_data", {32'h0, bus.out_data}, {32'h0, e});
      end
    end
    if (bus.in_valid && bus.in_ready && !(flush_req && flush_cnt != '0))
      exp_q.push_back(bus.in_data);
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] c, input logic [W-1:0] d);
    bus.in_valid = 1'b1;
    bus.in_data = a; tick();
    bus.in_data = b; tick();
    bus.in_data = c; tick();
    bus.in_data = d; tick();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain(input int n);
    bus.in_valid = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    rstn = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    stall_req = 1'b0;
    stall_stage = '0;
    flush_req = 1'b0;
    flush_cnt = '0;

    // reset state
    #3;
    chk("rst_valid", stage_valid, 0);
    chk("rst_occ", occupancy, 0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_out_data", bus.out_data, 0);
    chk("rst_out_fire", bus.out_fire, 0);
    chk("rst_in_ready", bus.in_ready, 1);
    chk("rst_data_lo", stage_data[63:0], 0);
    chk("rst_data_hi", stage_data[127:64], 0);
    @(posedge clk);
    @(negedge clk);
    rstn = 1'b1;
    @(posedge clk);
    #1;

    // stream 0x10..0x15
    for (int i = 0; i < 6; i++) begin
      bus.in_valid = 1'b1;
      bus.in_data = W'(32'h10 + i);
      tick();
      if (i == 2) chk("stream_not_yet", bus.out_valid, 0);
      if (i == 3) begin
        chk("stream_lat_valid", bus.out_valid, 1);
        chk("stream_lat_data", bus.out_data, 32'h10);
      end
    end
    chk("stream_occ_full", occupancy, 4);
    drain(4);
    chk("stream_occ_empty", occupancy, 0);
    chk("stream_q_empty", exp_q.size(), 0);

    // load-use stall at stage 1
    fill(32'hA3, 32'hA2, 32'hA1, 32'hA0);
    chk("lu_full", stage_valid, 4'b1111);
    stall_req = 1'b1;
    stall_stage = 2'd1;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hEE;
    #1;
    chk("lu_in_ready", bus.in_ready, 0);
    chk("lu_out_fire", bus.out_fire, 1);
    tick();
    bus.in_valid = 1'b0;
    chk("lu_valid", stage_valid, 4'b1011);
    chk("lu_s0", sd(0), 32'hA0);
    chk("lu_s1", sd(1), 32'hA1);
    chk("lu_s3", sd(3), 32'hA2);
    chk("lu_occ", occupancy, 3);

    // full hold for 3 cycles
    stall_stage = 2'd3;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("hold_fire", bus.out_fire, 0);
      chk("hold_ready", bus.in_ready, 0);
      tick();
      chk("hold_valid", stage_valid, 4'b1011);
      chk("hold_data_lo", stage_data[63:0], {32'hA1, 32'hA0});
      chk("hold_data_hi", stage_data[127:64], {32'hA2, 32'hA2});
      chk("hold_occ", occupancy, 3);
    end
    stall_req = 1'b0;
    drain(4);
    chk("lu_q_empty", exp_q.size(), 0);

    // branch flush of youngest 2
    fill(32'hB0, 32'hB1, 32'hB2, 32'hB3);
    flush_req = 1'b1;
    flush_cnt = 3'd2;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hFF;
    #1;
    chk("fl_in_ready", bus.in_ready, 1);
    chk("fl_out_fire", bus.out_fire, 1);
    tick();
    void'(exp_q.pop_back());
    void'(exp_q.pop_back());
    flush_req = 1'b0;
    bus.in_valid = 1'b0;
    chk("fl_valid", stage_valid, 4'b1000);
    chk("fl_s3", sd(3), 32'hB1);
    chk("fl_zero_lo", stage_data[63:0], 0);
    chk("fl_occ", occupancy, 1);
    drain(4);
    chk("fl_q_empty", exp_q.size(), 0);

    // flush and stall together: flush wins
    fill(32'hC0, 32'hC1, 32'hC2, 32'hC3);
    flush_req = 1'b1;
    flush_cnt = 3'd1;
    stall_req = 1'b1;
    stall_stage = 2'd3;
    bus.in_valid = 1'b1;
    bus.in_data = 32'hDD;
    #1;
    chk("fs_in_ready", bus.in_ready, 1);
    chk("fs_out_fire", bus.out_fire, 1);
    tick();
    void'(exp_q.pop_back());
    stall_req = 1'b0;
    bus.in_valid = 1'b0;
    chk("fs_valid", stage_valid, 4'b1100);
    chk("fs_s2", sd(2), 32'hC2);
    chk("fs_s3", sd(3), 32'hC1);
    chk("fs_occ", occupancy, 2);

    // flush count at DEPTH wipes the bank
    flush_cnt = 3'd4;
    tick();
    void'(exp_q.pop_back());
    chk("fall_valid", stage_valid, 0);
    chk("fall_occ", occupancy, 0);
    chk("fall_q_empty", exp_q.size(), 0);

    // zero flush count behaves as a plain shift
    flush_cnt = 3'd0;
    bus.in_valid = 1'b1;
    bus.in_data = 32'h77;
    tick();
    flush_req = 1'b0;
    chk("f0_valid", stage_valid, 4'b0001);
    chk("f0_s0", sd(0), 32'h77);
    drain(4);
    chk("f0_q_empty", exp_q.size(), 0);

    // async reset mid-cycle with the bank full
    fill(32'hD0, 32'hD1, 32'hD2, 32'hD3);
    #2;
    rstn = 1'b0;
    #1;
    chk("ar_valid", stage_valid, 0);
    chk("ar_occ", occupancy, 0);
    chk("ar_out_valid", bus.out_valid, 0);
    exp_q.delete();
    @(posedge clk);
    #1;
    rstn = 1'b1;
    drain(5);
    chk("ar_after_valid", stage_valid, 0);
`ifdef PIPE_PERF_EN
    chk("perf_bubble", bubble_cnt, 5);
    chk("perf_retire", retire_cnt, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/pipe_stage_bank.md
Name: pipe_stage_bank

Overview:
- Parametrised pipeline-register bank that replaces the hand-written per-stage register copies in the core top.
- Carries a WIDTH-bit payload, with a valid bit, through DEPTH stages. Stage 0 is youngest (Dec); stage DEPTH-1 is oldest (WB).
- Adds behaviour the current pipeline lacks: load-use style stall with bubble insertion, branch-redirect flush of the youngest K stages, and occupancy tracking.
- Sits between ifetch and the write-back consumer; one instance per payload group (control word, datapath word).

Parameters:
WIDTH, 32, payload bits per stage
DEPTH, 4, number of pipeline stages (2..8)
CW, $clog2(DEPTH+1), width of occupancy and flush count fields

Ports:
clk  input  1  rising-edge clock
rstn  input  1  asynchronous active-low reset
in_valid  input  1  new entry offered to stage 0
in_data  input  WIDTH  payload for stage 0
in_ready  output  1  stage 0 can accept; equals !stall_req || flush_req
stall_req  input  1  hold request
stall_stage  input  $clog2(DEPTH)  highest stage index held while stall_req=1
flush_req  input  1  squash request (branch redirect)
flush_cnt  input  CW  number of youngest stages squashed (1..DEPTH)
stage_valid  output  DEPTH  valid bit per stage, bit i = stage i
stage_data  output  DEPTH*WIDTH  flattened payloads, stage i at [i*WIDTH +: WIDTH]
out_valid  output  1  stage DEPTH-1 valid
out_data  output  WIDTH  stage DEPTH-1 payload
out_fire  output  1  out_valid && !(stall_req && !flush_req && stall_stage==DEPTH-1)
occupancy  output  CW  count of valid stages

Behaviour:
- Reset (rstn=0, asynchronous): all stage_valid=0, all stage_data=0, occupancy=0. Therefore out_valid=0, out_data=0, out_fire=0. in_ready follows its combinational equation.
- Normal cycle (no stall, no flush):
  - stage 0 <= {in_valid, in_data}
  - stage i <= stage i-1 for i>=1
  - latency in->out = DEPTH cycles.
- Stall (stall_req=1, flush_req=0, S=stall_stage):
  - stages 0..S hold valid and data
  - if S<DEPTH-1: stage S+1 <= bubble (valid=0, data held); stages >S+1 advance normally
  - if S=DEPTH-1: entire bank holds, no bubble
  - in_valid ignored (in_ready=0).
- Flush (flush_req=1, K=flush_cnt): overrides stall.
  - Squash mask is applied before the shift: the input and stages 0..K-1 are treated as invalid; then a normal shift occurs.
  - After the edge: stages 0..K are valid=0 (capped at DEPTH-1); stages K+1.. hold old stages K..
  - Data of squashed stages is don't-care; the implementation writes 0.
  - K=0 is treated as a normal cycle. K>=DEPTH invalidates the whole bank.
  - in_ready=1, but the offered entry is discarded.
- occupancy is registered. It is updated on the same edge as the stages and equals popcount of the next stage_valid.
- The bank never drops a valid entry except by flush; a held stage never loses data.
- Reset mid-stall or mid-flush: reset wins immediately; no state survives.

Optional Feature:
PIPE_PERF_EN
- Defined: adds outputs bubble_cnt[31:0] and retire_cnt[31:0], reset to 0.
  - bubble_cnt increments each cycle stage DEPTH-1 is invalid.
  - retire_cnt increments on each out_fire.
  - Both saturate at 32'hFFFF_FFFF and never wrap.
- Undefined: the ports and counters do not exist; the rest of the behaviour is unchanged.

Test Plan:
- Stream: DEPTH=4. Drive in_valid=1 with data 0x10,0x11,0x12,... for 6 cycles -> out_data=0x10 appears 4 cycles after first in_valid; then 0x11..0x15 back-to-back; occupancy=4 at steady state.
- Load-use stall: pipe full with A0..A3 (A3 oldest). stall_req=1, stall_stage=1 for 1 cycle -> next stage_valid=4'b1011; stage0/1 still hold A0/A1; stage3=A2; A3 retired with out_fire=1; in_ready=0 during the stall.
- Full hold: stall_stage=3 for 3 cycles -> stage contents unchanged, out_fire=0 all 3 cycles, occupancy constant.
- Branch flush: pipe full B0..B3 with in_valid=1 data 0xFF. flush_req=1, flush_cnt=2 -> next stage_valid=4'b1000, stage3=B1; 0xFF never appears at out_data.
- Flush plus stall in the same cycle: flush_cnt=1, stall_req=1, stall_stage=3 -> flush wins; bank shifts; stage_valid bits 0..1 = 0.
- Async reset mid-stream: drop rstn mid-cycle with pipe full -> stage_valid=0 and occupancy=0 immediately, before the next clk edge. With PIPE_PERF_EN, after 5 empty cycles following reset release: bubble_cnt=5, retire_cnt=0.
